// File: rtl/mor1kx_rf_ram_ctrl_if.sv
// rtl/mor1kx_rf_ram_ctrl_if.sv - client and RF RAM signal bundle for the RF RAM controller
interface mor1kx_rf_ram_ctrl_if #(
  parameter int AW = 5,
  parameter int OW = 32
);

  // Client side
  logic [AW-1:0] rd_addr_i;
  logic          rd_en_i;
  logic [OW-1:0] rd_data_o;
  logic [AW-1:0] wr_addr_i;
  logic          wr_en_i;
  logic [OW-1:0] wr_data_i;
  logic          busy_o;

  // RAM side
  logic [AW-1:0] ram_rdad_o;
  logic          ram_rden_o;
  logic [OW-1:0] ram_rdda_i;
  logic [AW-1:0] ram_wrad_o;
  logic          ram_wren_o;
  logic [OW-1:0] ram_wrda_o;

  // Environment view: pipeline client plus the RAM instance
  modport master (
    output rd_addr_i, rd_en_i, wr_addr_i, wr_en_i, wr_data_i, ram_rdda_i,
    input  rd_data_o, busy_o, ram_rdad_o, ram_rden_o, ram_wrad_o, ram_wren_o, ram_wrda_o
  );

  // Controller view
  modport slave (
    input  rd_addr_i, rd_en_i, wr_addr_i, wr_en_i, wr_data_i, ram_rdda_i,
    output rd_data_o, busy_o, ram_rdad_o, ram_rden_o, ram_wrad_o, ram_wren_o, ram_wrda_o
  );

endinterface

// File: rtl/mor1kx_rf_ram_ctrl.sv
// rtl/mor1kx_rf_ram_ctrl.sv - register file RAM client controller with zero-fill and read/write bypass
module mor1kx_rf_ram_ctrl #(
  parameter int OPTION_OPERAND_WIDTH    = 32,
  parameter int OPTION_RF_ADDR_WIDTH    = 5,
  parameter int OPTION_RF_WORDS         = 32,
  parameter int OPTION_RF_CLEAR_ON_INIT = 1
) (
  input logic                 clk,
  input logic                 rst,
  mor1kx_rf_ram_ctrl_if.slave bus
);

  localparam int AW = OPTION_RF_ADDR_WIDTH;
  localparam int OW = OPTION_OPERAND_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(OPTION_RF_WORDS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          byp_sel_q, byp_sel_d;
  logic [OW-1:0] byp_data_q, byp_data_d;

  // State, clear counter and bypass registers; bypass starts selected with zero so reads return 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (OPTION_RF_CLEAR_ON_INIT != 0) ? CLEAR : READY;
      clr_cnt_q  <= '0;
      byp_sel_q  <= 1'b1;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      byp_sel_q  <= byp_sel_d;
      byp_data_q <= byp_data_d;
    end
  end

  // Next state and RAM port drive: zero-fill sweep while clearing, pass-through with collision capture when ready
  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    byp_sel_d      = byp_sel_q;
    byp_data_d     = byp_data_q;
    bus.busy_o     = 1'b0;
    bus.ram_rdad_o = '0;
    bus.ram_rden_o = 1'b0;
    bus.ram_wrad_o = '0;
    bus.ram_wren_o = 1'b0;
    bus.ram_wrda_o = '0;

    case (state_q)
      CLEAR: begin
        // Client requests are ignored here; bypass registers hold
        bus.busy_o     = 1'b1;
        bus.ram_wren_o = 1'b1;
        bus.ram_wrad_o = clr_cnt_q;
        bus.ram_wrda_o = '0;
        if (clr_cnt_q == LAST_ADDR) begin
          // Final word written this cycle; counter parks instead of wrapping
          state_d = READY;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      READY: begin
        bus.ram_rdad_o = bus.rd_addr_i;
        bus.ram_rden_o = bus.rd_en_i;
        bus.ram_wrad_o = bus.wr_addr_i;
        bus.ram_wren_o = bus.wr_en_i;
        bus.ram_wrda_o = bus.wr_data_i;
        if (bus.rd_en_i) begin
          // RAM read data is undefined on a same-address collision, so serve it from the write data
          if (bus.wr_en_i && (bus.rd_addr_i == bus.wr_addr_i)) begin
            byp_sel_d  = 1'b1;
            byp_data_d = bus.wr_data_i;
          end else begin
            byp_sel_d = 1'b0;
          end
        end
      end

      default: state_d = READY;
    endcase
  end

  // Read data: bypass capture or the RAM's registered output; both hold while no read is issued
  assign bus.rd_data_o = byp_sel_q ? byp_data_q : bus.ram_rdda_i;

endmodule

// File: tb/tb_mor1kx_rf_ram_ctrl.sv
// tb/tb_mor1kx_rf_ram_ctrl.sv - self-checking bench for mor1kx_rf_ram_ctrl
module tb_mor1kx_rf_ram_ctrl;

  localparam int AW    = 5;
  localparam int OW    = 32;
  localparam int WORDS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mor1kx_rf_ram_ctrl_if #(.AW(AW), .OW(OW)) bus ();
  mor1kx_rf_ram_ctrl_if #(.AW(AW), .OW(OW)) bus2 ();

  mor1kx_rf_ram_ctrl #(
    .OPTION_OPERAND_WIDTH(OW),
    .OPTION_RF_ADDR_WIDTH(AW),
    .OPTION_RF_WORDS(WORDS),
    .OPTION_RF_CLEAR_ON_INIT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  mor1kx_rf_ram_ctrl #(
    .OPTION_OPERAND_WIDTH(OW),
    .OPTION_RF_ADDR_WIDTH(AW),
    .OPTION_RF_WORDS(WORDS),
    .OPTION_RF_CLEAR_ON_INIT(0)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  // RF RAM model: registered read, garbage on same-address collision, random power-up contents
  logic [OW-1:0] ram_mem [WORDS];
  logic [OW-1:0] ram_q;
  bit            seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < WORDS; i++) ram_mem[i] <= $urandom;
      ram_q  <= $urandom;
      seeded <= 1'b1;
    end else begin
      if (bus.ram_rden_o)
        ram_q <= (bus.ram_wren_o && bus.ram_wrad_o == bus.ram_rdad_o) ? ~bus.ram_wrda_o
                                                                       : ram_mem[bus.ram_rdad_o];
      if (bus.ram_wren_o) ram_mem[bus.ram_wrad_o] <= bus.ram_wrda_o;
    end
  end
  assign bus.ram_rdda_i  = ram_q;
  assign bus2.ram_rdda_i = '0;

  // Reference model: architectural RF contents and expected client view
  logic [OW-1:0] ref_mem [WORDS];
  logic [OW-1:0] exp_rd;
  bit            exp_busy;
  int            clr_done;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    bus.rd_en_i = 1'b0;
    bus.wr_en_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    exp_busy = 1'b1;
    clr_done = 0;
    exp_rd   = '0;
    check("reset_rd_data", bus.rd_data_o, '0);
    check("reset_busy", {31'b0, bus.busy_o}, 32'd1);
    check("reset_wrad", {27'b0, bus.ram_wrad_o}, 32'd0);
  endtask

  task automatic cyc(input bit re, input int ra, input bit we, input int wa, input logic [OW-1:0] wd);
    bus.rd_en_i   = re;
    bus.rd_addr_i = AW'(ra);
    bus.wr_en_i   = we;
    bus.wr_addr_i = AW'(wa);
    bus.wr_data_i = wd;
    #1;
    if (exp_busy) begin
      check("clr_wren", {31'b0, bus.ram_wren_o}, 32'd1);
      check("clr_wrad", {27'b0, bus.ram_wrad_o}, clr_done);
      check("clr_wrda", bus.ram_wrda_o, '0);
      check("clr_rden", {31'b0, bus.ram_rden_o}, 32'd0);
      clr_done++;
      if (clr_done == WORDS) begin
        exp_busy = 1'b0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
      end
    end else begin
      check("rdy_rden", {31'b0, bus.ram_rden_o}, {31'b0, re});
      check("rdy_wren", {31'b0, bus.ram_wren_o}, {31'b0, we});
      if (re) check("rdy_rdad", {27'b0, bus.ram_rdad_o}, ra);
      if (we) begin
        check("rdy_wrad", {27'b0, bus.ram_wrad_o}, wa);
        check("rdy_wrda", bus.ram_wrda_o, wd);
      end
      if (re) exp_rd = (we && ra == wa) ? wd : ref_mem[ra];
      if (we) ref_mem[wa] = wd;
    end
    @(posedge clk);
    #1;
    check("rd_data", bus.rd_data_o, exp_rd);
    check("busy", {31'b0, bus.busy_o}, {31'b0, exp_busy});
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 0, '0);
  endtask

  initial begin
    bus.rd_en_i    = 1'b0;
    bus.rd_addr_i  = '0;
    bus.wr_en_i    = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus2.rd_en_i   = 1'b0;
    bus2.rd_addr_i = '0;
    bus2.wr_en_i   = 1'b0;
    bus2.wr_addr_i = '0;
    bus2.wr_data_i = '0;
    exp_rd   = '0;
    exp_busy = 1'b1;
    clr_done = 0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);

    // Power-up clear: 32 busy cycles sweeping addresses 0..31 with zero data
    do_reset();
    check("dut2_busy_after_reset", {31'b0, bus2.busy_o}, 32'd0);
    check("dut2_rd_data_after_reset", bus2.rd_data_o, '0);
    for (int i = 0; i < WORDS; i++) idle();
    check("t1_busy_done", {31'b0, bus.busy_o}, 32'd0);

    // Write then read next cycle; untouched word reads zero
    cyc(1'b0, 0, 1'b1, 5, 32'hDEADBEEF);
    cyc(1'b1, 5, 1'b0, 0, '0);
    check("t2_read5", bus.rd_data_o, 32'hDEADBEEF);
    cyc(1'b1, 6, 1'b0, 0, '0);
    check("t2_read6", bus.rd_data_o, 32'h0);

    // Same-cycle read/write collision resolved by bypass
    cyc(1'b1, 7, 1'b1, 7, 32'h12345678);
    check("t3_bypass", bus.rd_data_o, 32'h12345678);

    // Held read data is not disturbed by later writes to the same address
    cyc(1'b1, 5, 1'b0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 0, 1'b1, 5, 32'h1);
      check("t4_hold", bus.rd_data_o, 32'hDEADBEEF);
    end
    cyc(1'b1, 5, 1'b0, 0, '0);
    check("t4_reread", bus.rd_data_o, 32'h1);

    // Reset mid-clear restarts the sweep from zero
    do_reset();
    for (int i = 0; i < 10; i++) idle();
    do_reset();
    for (int i = 0; i < WORDS - 1; i++) begin
      if (i == 4) cyc(1'b1, 3, 1'b1, 3, 32'hAAAAAAAA);
      else idle();
    end
    check("t5_still_busy", {31'b0, bus.busy_o}, 32'd1);
    idle();
    check("t5_busy_done", {31'b0, bus.busy_o}, 32'd0);
    cyc(1'b1, 3, 1'b0, 0, '0);
    check("t6_read3", bus.rd_data_o, 32'h0);

    // Randomized traffic against the reference model, collisions made frequent
    for (int n = 0; n < 400; n++) begin
      int ra, wa;
      ra = $urandom_range(0, WORDS - 1);
      wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, WORDS - 1);
      cyc(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, $urandom);
    end

    // Instance without zero-fill: immediately ready, pass-through and bypass
    bus2.rd_en_i   = 1'b1;
    bus2.rd_addr_i = 5'd9;
    bus2.wr_en_i   = 1'b1;
    bus2.wr_addr_i = 5'd9;
    bus2.wr_data_i = 32'hCAFEF00D;
    #1;
    check("dut2_wren", {31'b0, bus2.ram_wren_o}, 32'd1);
    check("dut2_wrda", bus2.ram_wrda_o, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    check("dut2_bypass", bus2.rd_data_o, 32'hCAFEF00D);
    bus2.wr_en_i = 1'b0;
    @(posedge clk);
    #1;
    check("dut2_ram_read", bus2.rd_data_o, 32'h0);
    bus2.rd_en_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
